// File: rtl/audio_sched_pkg.sv
// Shared types and constants for the audio stream scheduler.
// Default widths, saturation limits and counter bounds.
package audio_sched_pkg;

  localparam int SAMPLE_W_D = 16;
  localparam int ADDR_W_D = 16;
  localparam int SAT_MAX_D = 32767;
  localparam int SAT_MIN_D = -32768;
  localparam int UNDERRUN_MAX = 255;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_MIX,
    S_OUT
  } state_t;

endpackage

// File: rtl/audio_fx_seq.sv
// One-shot effect sequencer: ROM address and remaining-length counter.
// A new start reloads even mid-effect and wins over a same-cycle advance.
module audio_fx_seq
  import audio_sched_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] len,
  input  logic              advance,
  input  logic              abort,
  output logic              fx_rd,
  output logic [ADDR_W-1:0] fx_addr,
  output logic              fx_busy
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rem;
  logic              active;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr   <= '0;
      rem    <= '0;
      active <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start && len != '0) begin
      addr   <= base;
      rem    <= len;
      active <= 1'b1;
    end else if (advance && active) begin
      addr <= addr + ONE;
      rem  <= rem - ONE;
      if (rem == ONE) active <= 1'b0;
    end
  end

  assign fx_rd   = advance & active;
  assign fx_addr = addr;
  assign fx_busy = active;

endmodule

// File: rtl/audio_stream_sched.sv
// Codec sample scheduler: one mixed music+effect sample per request.
// Fetch, wait, mix, out; requests during a sample are held one-deep.
module audio_stream_sched
  import audio_sched_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int FX_SHIFT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                init_done,
  input  logic                data_req,
  input  logic                mute,
  input  logic                mus_valid,
  input  logic [SAMPLE_W-1:0] mus_data,
  output logic                mus_ready,
  input  logic                fx_start,
  input  logic [ADDR_W-1:0]   fx_base,
  input  logic [ADDR_W-1:0]   fx_len,
  output logic                fx_rd,
  output logic [ADDR_W-1:0]   fx_addr,
  input  logic [SAMPLE_W-1:0] fx_rdata,
  output logic                fx_busy,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic                smp_valid,
  output logic [7:0]          underrun_cnt
);

  localparam logic [SAMPLE_W-1:0] S_MAX =
    {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] S_MIN =
    {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [7:0] U_MAX = 8'(UNDERRUN_MAX);

  state_t state, state_nx;
  logic data_req_q;
  logic pending;
  logic fx_rd_q;
  logic signed [SAMPLE_W-1:0] mus_s;
  logic signed [SAMPLE_W-1:0] fx_s;
  logic signed [SAMPLE_W-1:0] fx_sh;
  logic signed [SAMPLE_W:0] sum;
  logic [SAMPLE_W-1:0] sat;
  logic req_edge;
  logic abort;
  logic fetch;
  logic busy;

  assign req_edge = data_req & ~data_req_q;
  assign abort = ~init_done & (state != S_INIT);
  assign fetch = init_done & (state == S_FETCH);
  assign busy = init_done & (state != S_INIT)
              & (state != S_IDLE);
  assign mus_ready = fetch & mus_valid;
  assign smp_valid = init_done & (state == S_OUT);

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = S_INIT;
    end else begin
      unique case (state)
        S_INIT:  if (init_done) state_nx = S_IDLE;
        S_IDLE:  if (req_edge || pending) state_nx = S_FETCH;
        S_FETCH: state_nx = S_WAIT;
        S_WAIT:  state_nx = S_MIX;
        S_MIX:   state_nx = S_OUT;
        S_OUT:   state_nx = S_IDLE;
        default: state_nx = S_INIT;
      endcase
    end
  end

  always_comb begin
    fx_sh = fx_s >>> FX_SHIFT;
    sum = {mus_s[SAMPLE_W-1], mus_s}
        + {fx_sh[SAMPLE_W-1], fx_sh};
    sat = sum[SAMPLE_W-1:0];
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
      sat = sum[SAMPLE_W] ? S_MIN : S_MAX;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_INIT;
      data_req_q   <= 1'b0;
      pending      <= 1'b0;
      fx_rd_q      <= 1'b0;
      mus_s        <= '0;
      fx_s         <= '0;
      smp_data     <= '0;
      underrun_cnt <= '0;
    end else begin
      state      <= state_nx;
      data_req_q <= data_req;
      fx_rd_q    <= fx_rd;
      unique case (1'b1)
        abort:
          pending <= 1'b0;
        init_done && state == S_IDLE:
          pending <= 1'b0;
        busy && req_edge:
          pending <= 1'b1;
        default: ;
      endcase
      if (fetch) begin
        mus_s <= mus_valid ? mus_data : '0;
        if (!mus_valid && underrun_cnt != U_MAX)
          underrun_cnt <= underrun_cnt + 8'd1;
      end
      if (init_done && state == S_WAIT)
        fx_s <= fx_rd_q ? fx_rdata : '0;
      if (init_done && state == S_MIX)
        smp_data <= mute ? '0 : sat;
    end
  end

  audio_fx_seq #(
    .ADDR_W(ADDR_W)
  ) u_fx (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (fx_start),
    .base    (fx_base),
    .len     (fx_len),
    .advance (fetch),
    .abort   (abort),
    .fx_rd   (fx_rd),
    .fx_addr (fx_addr),
    .fx_busy (fx_busy)
  );

endmodule
